// File: rtl/time_header_square.sv
// time_header_square
// Placement and visibility control for the 32x16 "TIME" header bitmap.
// Turns the VGA scan position into an inside-rectangle flag plus X/Y
// offsets relative to the header origin, and runs a frame-synchronous
// blink state machine that flashes the header when time is low and
// hides it when the game is not running.
module time_header_square #(
   parameter int TOP_LEFT_X      = 560,
   parameter int TOP_LEFT_Y      = 8,
   parameter int OBJECT_WIDTH_X  = 32,
   parameter int OBJECT_HEIGHT_Y = 16,
   parameter int BLINK_FRAMES    = 15
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        enable,
   input  logic        timeLow,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        headerVisible
);

   typedef enum logic [1:0] {
      HIDE      = 2'd0,
      SHOW      = 2'd1,
      BLINK_ON  = 2'd2,
      BLINK_OFF = 2'd3
   } state_t;

   // Rectangle bounds held in 12 bits so origin + size can never wrap.
   localparam logic [11:0] X_LO = 12'(TOP_LEFT_X);
   localparam logic [11:0] X_HI = 12'(TOP_LEFT_X + OBJECT_WIDTH_X);
   localparam logic [11:0] Y_LO = 12'(TOP_LEFT_Y);
   localparam logic [11:0] Y_HI = 12'(TOP_LEFT_Y + OBJECT_HEIGHT_Y);

   // Last frame-count value of a blink phase; a phase spans BLINK_FRAMES frames.
   localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        inside_q, inside_d;
   logic [10:0] offx_q, offx_d;
   logic [10:0] offy_q, offy_d;

   logic [11:0] px12;
   logic [11:0] py12;

   assign px12 = {1'b0, pixelX};
   assign py12 = {1'b0, pixelY};

   // Visibility is a pure decode of the registered state.
   assign headerVisible = (state_q == SHOW) || (state_q == BLINK_ON);

   // Blink FSM state and frame counter registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= HIDE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: only a start-of-frame pulse may move the FSM, so
   // visibility never changes in the middle of a frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (startOfFrame) begin
         if (!enable) begin
            state_d = HIDE;
         end else begin
            case (state_q)
               HIDE: begin
                  state_d = SHOW;
               end
               SHOW: begin
                  if (timeLow) begin
                     state_d = BLINK_ON;
                     cnt_d   = 8'd0;
                  end
               end
               BLINK_ON, BLINK_OFF: begin
                  if (!timeLow) begin
                     state_d = SHOW;
                  end else if (cnt_q == CNT_LAST) begin
                     state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
               default: begin
                  state_d = HIDE;
               end
            endcase
         end
      end
   end

   // Hit test and offsets; offsets are forced to zero outside the header
   // so the bitmap is never indexed out of range.
   always_comb begin
      inside_d = (px12 >= X_LO) && (px12 < X_HI) &&
                 (py12 >= Y_LO) && (py12 < Y_HI) &&
                 headerVisible;
      offx_d   = 11'd0;
      offy_d   = 11'd0;
      if (inside_d) begin
         offx_d = pixelX - X_LO[10:0];
         offy_d = pixelY - Y_LO[10:0];
      end
   end

   // One-cycle registered request outputs toward the bitmap.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         inside_q <= 1'b0;
         offx_q   <= 11'd0;
         offy_q   <= 11'd0;
      end else begin
         inside_q <= inside_d;
         offx_q   <= offx_d;
         offy_q   <= offy_d;
      end
   end

   assign InsideRectangle = inside_q;
   assign offsetX         = offx_q;
   assign offsetY         = offy_q;

endmodule

// File: tb/tb_time_header_square.sv
// Directed testbench for time_header_square (blink phase of 2 frames).
module tb_time_header_square;

   logic        clk;
   logic        resetN;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;
   logic        enable;
   logic        timeLow;
   logic        InsideRectangle;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        headerVisible;

   int n_cmp = 0;
   int n_err = 0;

   time_header_square #(
      .TOP_LEFT_X     (560),
      .TOP_LEFT_Y     (8),
      .OBJECT_WIDTH_X (32),
      .OBJECT_HEIGHT_Y(16),
      .BLINK_FRAMES   (2)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .startOfFrame   (startOfFrame),
      .enable         (enable),
      .timeLow        (timeLow),
      .InsideRectangle(InsideRectangle),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .headerVisible  (headerVisible)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   // Present one pixel, let it be registered, then check the request outputs.
   task automatic pix(input string tag, input int x, input int y,
                      input int ein, input int eox, input int eoy);
      pixelX = 11'(x);
      pixelY = 11'(y);
      tick();
      check({tag, "_inside"}, int'(InsideRectangle), ein);
      check({tag, "_offx"}, int'(offsetX), eox);
      check({tag, "_offy"}, int'(offsetY), eoy);
   endtask

   int blink_exp [6] = '{1, 1, 0, 0, 1, 1};

   initial begin
      resetN       = 1'b0;
      pixelX       = 11'd560;
      pixelY       = 11'd8;
      startOfFrame = 1'b0;
      enable       = 1'b0;
      timeLow      = 1'b0;
      tick();
      tick();
      check("rst_inside", int'(InsideRectangle), 0);
      check("rst_offx", int'(offsetX), 0);
      check("rst_offy", int'(offsetY), 0);
      check("rst_vis", int'(headerVisible), 0);
      resetN = 1'b1;
      tick();

      // Still hidden before any enabled frame start.
      pix("hide_pre", 560, 8, 0, 0, 0);

      // Enable and show.
      enable = 1'b1;
      sof();
      check("show_vis", int'(headerVisible), 1);
      pix("tl_corner", 560, 8, 1, 0, 0);
      pix("br_corner", 591, 23, 1, 31, 15);
      pix("right_out", 592, 8, 0, 0, 0);
      pix("left_out", 559, 8, 0, 0, 0);
      pix("below_out", 560, 24, 0, 0, 0);
      pix("above_out", 560, 7, 0, 0, 0);
      pix("mid", 575, 16, 1, 15, 8);

      // Blinking: two frames on, two off.
      timeLow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sof();
         check($sformatf("blink_vis%0d", i), int'(headerVisible), blink_exp[i]);
         pix($sformatf("blink_pix%0d", i), 570, 10, blink_exp[i],
             blink_exp[i] * 10, blink_exp[i] * 2);
      end
      sof();
      check("off_vis", int'(headerVisible), 0);

      // Drop timeLow mid-frame in BLINK_OFF: no change until next frame start.
      tick();
      timeLow = 1'b0;
      tick();
      tick();
      check("midframe_hold_vis", int'(headerVisible), 0);
      pix("midframe_hold_pix", 570, 10, 0, 0, 0);
      sof();
      check("back_show_vis", int'(headerVisible), 1);
      pix("back_show_pix", 570, 10, 1, 10, 2);

      // Enter BLINK_ON, then disable with timeLow still high: hide wins.
      timeLow = 1'b1;
      sof();
      check("blinkon_vis", int'(headerVisible), 1);
      enable = 1'b0;
      sof();
      check("hide_vis", int'(headerVisible), 0);
      for (int y = 8; y < 24; y++) begin
         for (int x = 560; x < 592; x++) begin
            pixelX = 11'(x);
            pixelY = 11'(y);
            tick();
            check($sformatf("hide_area_%0d_%0d", x, y), int'(InsideRectangle), 0);
         end
      end

      // Asynchronous reset mid-frame while visible.
      timeLow = 1'b0;
      enable  = 1'b1;
      sof();
      pix("pre_rst", 565, 12, 1, 5, 4);
      #2;
      resetN = 1'b0;
      #1;
      check("arst_inside", int'(InsideRectangle), 0);
      check("arst_offx", int'(offsetX), 0);
      check("arst_offy", int'(offsetY), 0);
      check("arst_vis", int'(headerVisible), 0);
      tick();
      resetN = 1'b1;
      pix("post_rst0", 565, 12, 0, 0, 0);
      pix("post_rst1", 565, 12, 0, 0, 0);
      check("post_rst_vis", int'(headerVisible), 0);
      enable = 1'b0;
      sof();
      check("post_rst_dis_vis", int'(headerVisible), 0);
      pix("post_rst_dis", 565, 12, 0, 0, 0);
      enable = 1'b1;
      sof();
      check("post_rst_en_vis", int'(headerVisible), 1);
      pix("post_rst_en", 565, 12, 1, 5, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/time_header_square.md
# time_header_square

Position and visibility controller for the 32x16 "TIME" header bitmap. It converts the VGA scan coordinates into the bitmap's request signals: an inside-rectangle flag and X/Y offsets relative to the header's top-left corner. It also runs a frame-synchronous blink state machine, so the header flashes when remaining time is low and disappears when the game is not running. It sits between the VGA sync generator and the header bitmap, feeding that bitmap's `InsideRectangle`/`offsetX`/`offsetY` inputs.

## Interface
- `TOP_LEFT_X`, default 560: header left column in pixels.
- `TOP_LEFT_Y`, default 8: header top row in pixels.
- `OBJECT_WIDTH_X`, default 32: header width. Must match the bitmap width.
- `OBJECT_HEIGHT_Y`, default 16: header height. Must match the bitmap height.
- `BLINK_FRAMES`, default 15: frames per blink phase. Legal range 1..255.
- `clk` in 1: pixel clock.
- `resetN` in 1: asynchronous, active-low reset.
- `pixelX` in 11: current scan column.
- `pixelY` in 11: current scan row.
- `startOfFrame` in 1: one-cycle pulse at the start of each frame.
- `enable` in 1: game running; the header may be displayed.
- `timeLow` in 1: remaining time is below threshold; requests blinking.
- `InsideRectangle` out 1: the registered pixel is inside the header and the header is visible.
- `offsetX` out 11: `pixelX - TOP_LEFT_X` when inside, else 0.
- `offsetY` out 11: `pixelY - TOP_LEFT_Y` when inside, else 0.
- `headerVisible` out 1: the current state is SHOW or BLINK_ON.

## Operation
- FSM states: HIDE, SHOW, BLINK_ON, BLINK_OFF. Reset state is HIDE.
- State transitions are evaluated only in cycles where `startOfFrame`=1. In all other cycles the state holds. This guarantees no mid-frame tearing.
- Transitions on `startOfFrame`, in priority order:
  - `enable`=0: any state goes to HIDE.
  - HIDE, `enable`=1: goes to SHOW, regardless of `timeLow`.
  - SHOW, `timeLow`=1: goes to BLINK_ON, frame counter cleared.
  - BLINK_ON or BLINK_OFF, `timeLow`=0: goes to SHOW.
  - BLINK_ON or BLINK_OFF, `timeLow`=1:
    - If the counter equals `BLINK_FRAMES`-1, toggle to the other blink state and clear the counter.
    - Otherwise increment the counter.
- Frame counter is 8 bits. It is cleared on every entry to a blink state and on reset. It never exceeds `BLINK_FRAMES`-1.
- Each blink phase lasts exactly `BLINK_FRAMES` frames, so a full blink period is 2×`BLINK_FRAMES` frames.
- Hit test, evaluated per cycle:
  - `pixelX` >= `TOP_LEFT_X` and `pixelX` < `TOP_LEFT_X`+`OBJECT_WIDTH_X`
  - and `pixelY` >= `TOP_LEFT_Y` and `pixelY` < `TOP_LEFT_Y`+`OBJECT_HEIGHT_Y`
  - and `headerVisible`.
- Arithmetic: compare in 12 bits so `TOP_LEFT`+size never wraps. Offsets are 11-bit unsigned subtractions, computed only when inside. When outside, offsets are forced to 0, so the bitmap never sees an out-of-range index.

## Timing
- `InsideRectangle`, `offsetX` and `offsetY` are registered: 1-cycle latency from `pixelX`/`pixelY`.
- The header bitmap adds 1 more cycle, so total latency is 2 cycles. The VGA path must delay sync by 2.
- `headerVisible` is the registered state. It changes in the cycle after the `startOfFrame` pulse that caused the transition.
- The hit test uses the `headerVisible` value from the same cycle. The first pixel of a new frame is therefore already drawn with the new visibility, because the `startOfFrame` pulse precedes the active pixels.
- Reset values: all outputs 0, state HIDE, counter 0.
- Reset asserted mid-blink: outputs go to 0 immediately (asynchronously). After release, the block waits in HIDE for the next `startOfFrame` with `enable`=1.
- Simultaneous `enable`=0 and `timeLow`=1 at `startOfFrame`: HIDE wins.
- `timeLow` toggling between frames: ignored until the next `startOfFrame`.

## Test plan
- Reset, then `enable`=1 and one `startOfFrame`. Pixel (560,8) gives `InsideRectangle`=1 with offsets (0,0) one cycle later. Pixel (591,23) gives offsets (31,15).
- Boundary pixels (592,8), (559,8) and (560,24): `InsideRectangle`=0 and offsets (0,0).
- `BLINK_FRAMES`=2, SHOW state, `timeLow`=1:
  - `headerVisible` sequence over successive frames is 1,1,0,0,1,1…
  - Pixel (570,10) draws only in ON frames.
- In BLINK_OFF, drop `timeLow` to 0 mid-frame. Visibility stays 0 until the next `startOfFrame`, then becomes 1 (SHOW).
- In BLINK_ON, apply `enable`=0 together with `timeLow`=1 at `startOfFrame`. State goes to HIDE and `InsideRectangle` stays 0 over the whole header area.
- Assert `resetN`=0 mid-frame with the header visible. Outputs go to 0 within the same cycle. After release, nothing is drawn until the first `startOfFrame` with `enable`=1.
